mem_io_responder: RTL and testbench

- Memory-side responder for the CPU's byte-wide external bus: `mem_a`, `mem_wr`, CPU `mem_dout` and CPU `mem_din`.
- Provides a byte-addressed RAM with 1-cycle read latency, plus the I/O window at `mem_a[17:16]==2'b11`: UART TX/RX byte FIFOs, a cycle counter and a halt register.
- Used as the memory/IO model in simulation and as the on-chip RAM plus UART bridge on FPGA.

---
 rtl/mem_io_pkg.sv | 35 +++
 rtl/mem_io_responder_if.sv | 34 +++
 rtl/byte_fifo.sv | 62 ++++++
 rtl/mem_io_responder.sv | 167 ++++++++++++++++
 tb/tb_mem_io_responder.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_io_pkg.sv
// Shared definitions for the memory/IO responder.
//   IO_SEL       : value of mem_a[17:16] that selects the I/O window
//   IO_UART_OFF  : I/O offset of the UART data port (TX push / RX pop)
//   IO_CLK_OFF   : I/O offset of the cycle-counter window (reads 4..7) and halt (write 4)
//   byte_t       : one bus byte
//   io_access_e  : decoded access kind for the current cycle
//   word_byte()  : byte k of a 32-bit word, k=0 is the LSB
package mem_io_pkg;

    localparam logic [1:0] IO_SEL      = 2'b11;
    localparam logic [2:0] IO_UART_OFF = 3'd0;
    localparam logic [2:0] IO_CLK_OFF  = 3'd4;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        NONE,
        RAM_RD,
        RAM_WR,
        IO_RD,
        IO_WR
    } io_access_e;

    function automatic byte_t word_byte(input logic [31:0] w, input logic [1:0] k);
        byte_t b;
        case (k)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// Bus bundle between the CPU/UART side and the memory/IO responder.
//   CPU bus : cpu_rdy, mem_a, mem_wr, mem_wdata (to responder), mem_rdata (from responder)
//   TX UART : tx_data, tx_valid (from responder), tx_ready (to responder)
//   RX UART : rx_data, rx_valid (to responder), rx_ready (from responder)
//   Status  : io_buffer_full, halt (from responder)
// Modports: master = CPU/UART side, slave = responder.
interface mem_io_responder_if;
    import mem_io_pkg::*;

    logic        cpu_rdy;
    logic [31:0] mem_a;
    logic        mem_wr;
    byte_t       mem_wdata;
    byte_t       mem_rdata;
    logic        io_buffer_full;
    byte_t       tx_data;
    logic        tx_valid;
    logic        tx_ready;
    byte_t       rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        halt;

    modport master (
        output cpu_rdy, mem_a, mem_wr, mem_wdata, tx_ready, rx_data, rx_valid,
        input  mem_rdata, io_buffer_full, tx_data, tx_valid, rx_ready, halt
    );

    modport slave (
        input  cpu_rdy, mem_a, mem_wr, mem_wdata, tx_ready, rx_data, rx_valid,
        output mem_rdata, io_buffer_full, tx_data, tx_valid, rx_ready, halt
    );

endinterface

// File: rtl/byte_fifo.sv
// Circular byte FIFO with an occupancy count register.
//   clk, rst_n : clock, synchronous active-low reset (empties the FIFO)
//   push       : write push_data; accepted when not full, or when a pop happens the same cycle
//   pop        : drop the head byte; ignored when empty
//   head       : current head byte (undefined when empty)
//   count      : number of stored bytes, 0..DEPTH
//   full/empty : count==DEPTH / count==0
// DEPTH must be a power of two so the pointers wrap naturally.
module byte_fifo
    import mem_io_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  byte_t                    push_data,
    input  logic                     pop,
    output byte_t                    head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    byte_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mem_io_responder.sv
// Memory-side responder for the CPU byte bus: byte-addressed RAM with
// one-cycle read latency plus an I/O window at mem_a[17:16]==2'b11
// holding UART TX/RX FIFOs, a free-running cycle counter and a halt flag.
//   clk_in  : system clock
//   rst_in  : synchronous active-low reset (RAM contents are kept)
//   bus     : mem_io_responder_if.slave (CPU bus, UART TX/RX, status)
// I/O map (mem_a[2:0]): rd 0 = RX pop, rd 4..7 = counter snapshot bytes,
//                       wr 0 = TX push (0x00 ignored), wr 4 = halt + 0x00 marker.
// Optional build macro MEM_IO_RAM_PRELOAD_EN: adds the INIT_FILE parameter;
// RAM power-up content is undefined.
module mem_io_responder
    import mem_io_pkg::*;
#(
    parameter int ADDR_W      = 17,
    parameter int TX_DEPTH    = 16,
    parameter int RX_DEPTH    = 16,
    parameter int FULL_MARGIN = 2
`ifdef MEM_IO_RAM_PRELOAD_EN
    ,
    parameter string INIT_FILE = "test.data"
`endif
) (
    input  logic               clk_in,
    input  logic               rst_in,
    mem_io_responder_if.slave  bus
);

    // ---------------------------------------------------------------
    // Access decode
    // ---------------------------------------------------------------
    logic                      halt_q;
    logic                      access;
    io_access_e                acc_kind;
    logic [2:0]                io_off;
    logic [ADDR_W-1:0]         ram_addr;
    logic                      unused_addr_bits;

    assign access           = bus.cpu_rdy & ~halt_q;
    assign io_off           = bus.mem_a[2:0];
    assign ram_addr         = bus.mem_a[ADDR_W-1:0];
    assign unused_addr_bits = ^bus.mem_a[31:18];

    always_comb begin
        acc_kind = NONE;
        if (access) begin
            if (bus.mem_a[17:16] == IO_SEL) acc_kind = bus.mem_wr ? IO_WR : IO_RD;
            else                            acc_kind = bus.mem_wr ? RAM_WR : RAM_RD;
        end
    end

    // ---------------------------------------------------------------
    // FIFOs
    // ---------------------------------------------------------------
    logic                      tx_push;
    byte_t                     tx_push_data;
    logic                      tx_full;
    logic                      tx_empty;
    byte_t                     tx_head;
    logic [$clog2(TX_DEPTH):0] tx_count;

    logic                      rx_push;
    logic                      rx_pop;
    logic                      rx_full;
    logic                      rx_empty;
    byte_t                     rx_head;
    logic [$clog2(RX_DEPTH):0] rx_count_unused;

    // The halt marker bypasses the near-full threshold; FULL_MARGIN keeps a
    // slot free for it as long as software honours io_buffer_full.
    assign tx_push      = (acc_kind == IO_WR) &&
                          (((io_off == IO_UART_OFF) && (bus.mem_wdata != 8'h00)) ||
                           (io_off == IO_CLK_OFF));
    assign tx_push_data = (io_off == IO_CLK_OFF) ? 8'h00 : bus.mem_wdata;

    assign rx_push = bus.rx_valid & ~rx_full;
    assign rx_pop  = (acc_kind == IO_RD) && (io_off == IO_UART_OFF) && !rx_empty;

    byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk       (clk_in),
        .rst_n     (rst_in),
        .push      (tx_push),
        .push_data (tx_push_data),
        .pop       (bus.tx_ready),
        .head      (tx_head),
        .count     (tx_count),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk       (clk_in),
        .rst_n     (rst_in),
        .push      (rx_push),
        .push_data (bus.rx_data),
        .pop       (rx_pop),
        .head      (rx_head),
        .count     (rx_count_unused),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    // ---------------------------------------------------------------
    // RAM
    // ---------------------------------------------------------------
    byte_t ram [2**ADDR_W];

    always_ff @(posedge clk_in) begin
        if (acc_kind == RAM_WR) ram[ram_addr] <= bus.mem_wdata;
    end

    // ---------------------------------------------------------------
    // I/O read mux
    // ---------------------------------------------------------------
    logic [31:0] cyc_cnt;
    logic [31:0] snap;
    byte_t       io_rdata;

    always_comb begin
        io_rdata = 8'h00;
        case (io_off)
            IO_UART_OFF: io_rdata = rx_empty ? 8'h00 : rx_head;
            // Offset 4 refreshes the snapshot this edge, so its byte comes
            // straight from the live counter.
            IO_CLK_OFF:  io_rdata = cyc_cnt[7:0];
            3'd5, 3'd6, 3'd7: io_rdata = word_byte(snap, io_off[1:0]);
            default:     io_rdata = 8'h00;
        endcase
    end

    // ---------------------------------------------------------------
    // Registered read data, counter, snapshot, halt, near-full flag
    // ---------------------------------------------------------------
    byte_t rdata_p0;
    logic  buf_full_q;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            rdata_p0   <= 8'h00;
            halt_q     <= 1'b0;
            cyc_cnt    <= '0;
            snap       <= '0;
            buf_full_q <= 1'b0;
        end else begin
            cyc_cnt    <= cyc_cnt + 32'd1;
            buf_full_q <= (TX_DEPTH - int'(tx_count)) <= FULL_MARGIN;
            case (acc_kind)
                RAM_RD: rdata_p0 <= ram[ram_addr];
                IO_RD: begin
                    rdata_p0 <= io_rdata;
                    if (io_off == IO_CLK_OFF) snap <= cyc_cnt;
                end
                IO_WR: begin
                    if (io_off == IO_CLK_OFF) halt_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_rdata      = rdata_p0;
    assign bus.halt           = halt_q;
    assign bus.io_buffer_full = buf_full_q;
    assign bus.tx_data        = tx_head;
    assign bus.tx_valid       = ~tx_empty;
    assign bus.rx_ready       = ~rx_full;

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: table-driven RAM vectors plus
// hand-written sequences for the TX/RX FIFOs, counter snapshot and halt.
module tb_mem_io_responder;
    import mem_io_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_io_responder_if bus_if ();

    mem_io_responder dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .bus    (bus_if)
    );

    int checks = 0;
    int errors = 0;

    // Reference cycle counter: same value the DUT counter holds between edges.
    logic [31:0] model_cnt;
    always @(posedge clk) model_cnt <= !rst_n ? 32'd0 : model_cnt + 32'd1;

    // Bytes consumed by the UART side.
    byte_t tx_log [$];
    always @(posedge clk) begin
        if (rst_n && bus_if.tx_valid && bus_if.tx_ready) tx_log.push_back(bus_if.tx_data);
    end

    typedef struct {
        logic        wr;
        logic [31:0] a;
        byte_t       wd;
        byte_t       exp;
    } vec_t;

    vec_t vecs [12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic acc(input logic wr, input logic [31:0] a, input byte_t d);
        bus_if.cpu_rdy   = 1'b1;
        bus_if.mem_wr    = wr;
        bus_if.mem_a     = a;
        bus_if.mem_wdata = d;
        tick();
        bus_if.cpu_rdy   = 1'b0;
        bus_if.mem_wr    = 1'b0;
    endtask

    byte_t b0, b1, b2, b3;
    int    guard;

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0100, 8'hA5, 8'h00};
        vecs[1]  = '{1'b0, 32'h0000_0100, 8'h00, 8'hA5};
        vecs[2]  = '{1'b1, 32'h0000_0200, 8'h3C, 8'hA5};
        vecs[3]  = '{1'b0, 32'h0000_0200, 8'h00, 8'h3C};
        vecs[4]  = '{1'b1, 32'h0000_0100, 8'h5A, 8'h3C};
        vecs[5]  = '{1'b0, 32'h0000_0100, 8'h00, 8'h5A};
        vecs[6]  = '{1'b0, 32'hABCC_0200, 8'h00, 8'h3C};
        vecs[7]  = '{1'b1, 32'h0001_FFFF, 8'h77, 8'h3C};
        vecs[8]  = '{1'b0, 32'h0001_FFFF, 8'h00, 8'h77};
        vecs[9]  = '{1'b0, 32'h0003_0001, 8'h00, 8'h00};
        vecs[10] = '{1'b0, 32'h0000_0100, 8'h00, 8'h5A};
        vecs[11] = '{1'b1, 32'h0003_0002, 8'hFF, 8'h5A};

        rst_n            = 1'b0;
        bus_if.cpu_rdy   = 1'b0;
        bus_if.mem_a     = 32'h0;
        bus_if.mem_wr    = 1'b0;
        bus_if.mem_wdata = 8'h00;
        bus_if.tx_ready  = 1'b0;
        bus_if.rx_data   = 8'h00;
        bus_if.rx_valid  = 1'b0;
        repeat (3) tick();

        chk("rst_rdata", bus_if.mem_rdata, 8'h00);
        chk("rst_halt", bus_if.halt, 1'b0);
        chk("rst_buf_full", bus_if.io_buffer_full, 1'b0);
        chk("rst_tx_valid", bus_if.tx_valid, 1'b0);
        chk("rst_rx_ready", bus_if.rx_ready, 1'b1);
        rst_n = 1'b1;

        // RAM vectors
        for (int i = 0; i < 12; i++) begin
            acc(vecs[i].wr, vecs[i].a, vecs[i].wd);
            chk($sformatf("ram_vec%0d", i), bus_if.mem_rdata, vecs[i].exp);
        end
        chk("io_wr_other_no_tx", bus_if.tx_valid, 1'b0);

        // Counter snapshot: start the 4-byte read with the counter at 0x1FF
        guard = 0;
        while (model_cnt != 32'h1FF && guard < 2000) begin
            tick();
            guard++;
        end
        chk("cnt_wait_bound", guard < 2000, 1'b1);
        acc(1'b0, 32'h0003_0004, 8'h00); b0 = bus_if.mem_rdata;
        acc(1'b0, 32'h0003_0005, 8'h00); b1 = bus_if.mem_rdata;
        acc(1'b0, 32'h0003_0006, 8'h00); b2 = bus_if.mem_rdata;
        acc(1'b0, 32'h0003_0007, 8'h00); b3 = bus_if.mem_rdata;
        chk("cnt_snapshot", {b3, b2, b1, b0}, 32'h0000_01FF);

        // cpu_rdy low for 5 cycles: no read, no TX push, counter keeps running
        bus_if.cpu_rdy = 1'b0;
        bus_if.mem_wr  = 1'b0;
        bus_if.mem_a   = 32'h0000_0100;
        repeat (3) tick();
        chk("rdy_low_rdata_hold", bus_if.mem_rdata, 8'h00);
        bus_if.mem_wr    = 1'b1;
        bus_if.mem_a     = 32'h0003_0000;
        bus_if.mem_wdata = 8'h41;
        repeat (2) tick();
        bus_if.mem_wr = 1'b0;
        chk("rdy_low_no_tx", bus_if.tx_valid, 1'b0);
        acc(1'b0, 32'h0003_0004, 8'h00); b0 = bus_if.mem_rdata;
        acc(1'b0, 32'h0003_0005, 8'h00); b1 = bus_if.mem_rdata;
        acc(1'b0, 32'h0003_0006, 8'h00); b2 = bus_if.mem_rdata;
        acc(1'b0, 32'h0003_0007, 8'h00); b3 = bus_if.mem_rdata;
        chk("cnt_after_idle", {b3, b2, b1, b0}, 32'h0000_0208);

        // TX: 'H','i',0x00 with the UART always ready
        tx_log.delete();
        bus_if.tx_ready = 1'b1;
        acc(1'b1, 32'h0003_0000, 8'h48);
        acc(1'b1, 32'h0003_0000, 8'h69);
        acc(1'b1, 32'h0003_0000, 8'h00);
        repeat (3) tick();
        chk("tx_hi_len", tx_log.size(), 2);
        if (tx_log.size() == 2) begin
            chk("tx_hi_0", tx_log[0], 8'h48);
            chk("tx_hi_1", tx_log[1], 8'h69);
        end
        chk("tx_hi_drained", bus_if.tx_valid, 1'b0);

        // TX near-full, full drop, push+pop while full
        tx_log.delete();
        bus_if.tx_ready = 1'b0;
        for (int i = 1; i <= 14; i++) acc(1'b1, 32'h0003_0000, byte_t'(i));
        chk("buf_full_lag", bus_if.io_buffer_full, 1'b0);
        acc(1'b1, 32'h0003_0000, 8'd15);
        chk("buf_full_set", bus_if.io_buffer_full, 1'b1);
        acc(1'b1, 32'h0003_0000, 8'd16);
        acc(1'b1, 32'h0003_0000, 8'd17);
        chk("buf_full_hold", bus_if.io_buffer_full, 1'b1);
        bus_if.tx_ready = 1'b1;
        acc(1'b1, 32'h0003_0000, 8'd18);
        repeat (20) tick();
        chk("tx_full_len", tx_log.size(), 17);
        if (tx_log.size() == 17) begin
            for (int i = 0; i < 16; i++) chk($sformatf("tx_full_%0d", i), tx_log[i], i + 1);
            chk("tx_full_pushpop", tx_log[16], 8'd18);
        end
        chk("buf_full_clear", bus_if.io_buffer_full, 1'b0);
        bus_if.tx_ready = 1'b0;

        // RX: two bytes then an empty read
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = 8'h31;
        tick();
        bus_if.rx_data  = 8'h32;
        tick();
        bus_if.rx_valid = 1'b0;
        acc(1'b0, 32'h0003_0000, 8'h00);
        chk("rx_0", bus_if.mem_rdata, 8'h31);
        acc(1'b0, 32'h0003_0000, 8'h00);
        chk("rx_1", bus_if.mem_rdata, 8'h32);
        acc(1'b0, 32'h0003_0000, 8'h00);
        chk("rx_empty", bus_if.mem_rdata, 8'h00);

        // RX fill to full, extra byte dropped
        bus_if.rx_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus_if.rx_data = byte_t'(8'h40 + i);
            tick();
        end
        chk("rx_full_ready", bus_if.rx_ready, 1'b0);
        bus_if.rx_data = 8'h99;
        tick();
        bus_if.rx_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            acc(1'b0, 32'h0003_0000, 8'h00);
            chk($sformatf("rx_full_%0d", i), bus_if.mem_rdata, 8'h40 + i);
        end
        acc(1'b0, 32'h0003_0000, 8'h00);
        chk("rx_full_dropped", bus_if.mem_rdata, 8'h00);
        chk("rx_ready_again", bus_if.rx_ready, 1'b1);

        // Halt
        acc(1'b1, 32'h0000_0010, 8'h11);
        acc(1'b0, 32'h0000_0010, 8'h00);
        chk("pre_halt_rd", bus_if.mem_rdata, 8'h11);
        acc(1'b1, 32'h0003_0004, 8'h00);
        chk("halt_set", bus_if.halt, 1'b1);
        chk("halt_marker_valid", bus_if.tx_valid, 1'b1);
        chk("halt_marker_data", bus_if.tx_data, 8'h00);
        acc(1'b1, 32'h0000_0010, 8'hEE);
        acc(1'b0, 32'h0000_0100, 8'h00);
        chk("halt_rdata_hold", bus_if.mem_rdata, 8'h11);
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = 8'h55;
        tick();
        bus_if.rx_valid = 1'b0;
        chk("halt_sticky", bus_if.halt, 1'b1);

        // Reset mid-operation
        rst_n = 1'b0;
        tick();
        chk("rst2_halt", bus_if.halt, 1'b0);
        chk("rst2_tx_valid", bus_if.tx_valid, 1'b0);
        chk("rst2_rdata", bus_if.mem_rdata, 8'h00);
        rst_n = 1'b1;
        acc(1'b0, 32'h0000_0010, 8'h00);
        chk("halt_blocked_ram_wr", bus_if.mem_rdata, 8'h11);
        acc(1'b0, 32'h0003_0000, 8'h00);
        chk("rst2_rx_emptied", bus_if.mem_rdata, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
